// File: rtl/i2c_target_write.sv
// ---------------------------------------------------------------------------
// i2c_target_write
//
// Write-only I2C target. It receives a device byte, then a register-address
// byte, then any number of data bytes. Each data byte is reported on a
// one-clk valid pulse, together with the register address it belongs to.
// The address pointer starts at the address byte and advances by one after
// every data byte, wrapping modulo 256. Every matched byte is ACKed. The
// block never stretches scl.
//
// Parameters
//   DEVICE : full first-byte match value (7-bit address plus R/W bit, W=0)
//
// Ports
//   clk   in     sole clock, all logic on posedge
//   rst   in     synchronous active-high reset
//   scl   inout  I2C clock, sampled only (always released)
//   sda   inout  I2C data, open drain (driven only to 0 or z)
//   valid out    one-clk pulse per received data byte
//   addr  out    register address of the data byte, held between pulses
//   data  out    received data byte, held between pulses
//   busy  out    high from a matched device byte until STOP or next START
// ---------------------------------------------------------------------------
module i2c_target_write #(
  parameter logic [7:0] DEVICE = 8'hA0
) (
  input  logic       clk,
  input  logic       rst,
  inout  wire        scl,
  inout  wire        sda,
  output logic       valid,
  output logic [7:0] addr,
  output logic [7:0] data,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE,
    DEV,
    ACK_DEV,
    ADDR,
    ACK_ADDR,
    DATA,
    ACK_DATA
  } state_t;

  // ---------------------------------------------------------------------
  // Pin synchronizers: two flops plus one history flop per line.
  // ---------------------------------------------------------------------
  logic scl_meta_reg, scl_sync_reg, scl_hist_reg;
  logic sda_meta_reg, sda_sync_reg, sda_hist_reg;

  // Counts the clocks after reset until the history flops hold real pin
  // values. Until then the reset value of 1 could fake an edge, START or
  // STOP out of bus activity that was already in progress.
  logic [1:0] settle_reg;
  logic       settled;

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_meta_reg <= 1'b1;
      scl_sync_reg <= 1'b1;
      scl_hist_reg <= 1'b1;
      sda_meta_reg <= 1'b1;
      sda_sync_reg <= 1'b1;
      sda_hist_reg <= 1'b1;
      settle_reg   <= 2'd0;
    end else begin
      scl_meta_reg <= scl;
      scl_sync_reg <= scl_meta_reg;
      scl_hist_reg <= scl_sync_reg;
      sda_meta_reg <= sda;
      sda_sync_reg <= sda_meta_reg;
      sda_hist_reg <= sda_sync_reg;
      if (settle_reg != 2'd3) begin
        settle_reg <= settle_reg + 2'd1;
      end
    end
  end

  assign settled = (settle_reg == 2'd3);

  // ---------------------------------------------------------------------
  // Bus events from the synchronized/history pair.
  // START/STOP require scl high in both samples, so they can never
  // coincide with an scl edge seen in the same clk.
  // ---------------------------------------------------------------------
  logic scl_rise, scl_fall, start_evt, stop_evt;

  assign scl_rise  = settled &  scl_sync_reg & ~scl_hist_reg;
  assign scl_fall  = settled & ~scl_sync_reg &  scl_hist_reg;
  assign start_evt = settled & scl_sync_reg & scl_hist_reg &
                     sda_hist_reg & ~sda_sync_reg;
  assign stop_evt  = settled & scl_sync_reg & scl_hist_reg &
                     ~sda_hist_reg & sda_sync_reg;

  // ---------------------------------------------------------------------
  // FSM and datapath registers
  // ---------------------------------------------------------------------
  state_t     state_reg, state_next;
  logic [2:0] bit_cnt_reg, bit_cnt_next;
  logic       byte_done_reg, byte_done_next;  // 8 bits shifted, awaiting scl fall
  logic [7:0] shift_reg, shift_next;
  logic [7:0] pointer_reg, pointer_next;
  logic       valid_reg, valid_next;
  logic [7:0] addr_reg, addr_next;
  logic [7:0] data_reg, data_next;
  logic       busy_reg, busy_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      bit_cnt_reg   <= 3'd0;
      byte_done_reg <= 1'b0;
      shift_reg     <= 8'h00;
      pointer_reg   <= 8'h00;
      valid_reg     <= 1'b0;
      addr_reg      <= 8'h00;
      data_reg      <= 8'h00;
      busy_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      bit_cnt_reg   <= bit_cnt_next;
      byte_done_reg <= byte_done_next;
      shift_reg     <= shift_next;
      pointer_reg   <= pointer_next;
      valid_reg     <= valid_next;
      addr_reg      <= addr_next;
      data_reg      <= data_next;
      busy_reg      <= busy_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    bit_cnt_next   = bit_cnt_reg;
    byte_done_next = byte_done_reg;
    shift_next     = shift_reg;
    pointer_next   = pointer_reg;
    valid_next     = 1'b0;
    addr_next      = addr_reg;
    data_next      = data_reg;
    busy_next      = busy_reg;

    if (start_evt) begin
      // Covers repeated START as well: any partial byte is dropped.
      state_next     = DEV;
      bit_cnt_next   = 3'd0;
      byte_done_next = 1'b0;
      busy_next      = 1'b0;
    end else if (stop_evt) begin
      state_next     = IDLE;
      bit_cnt_next   = 3'd0;
      byte_done_next = 1'b0;
      busy_next      = 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          // Only START leaves IDLE.
        end

        DEV, ADDR, DATA: begin
          if (scl_rise && !byte_done_reg) begin
            shift_next   = {shift_reg[6:0], sda_sync_reg};
            bit_cnt_next = bit_cnt_reg + 3'd1;
            if (bit_cnt_reg == 3'd7) begin
              byte_done_next = 1'b1;
            end
          end else if (scl_fall && byte_done_reg) begin
            // The falling edge after the 8th bit opens the ACK slot.
            byte_done_next = 1'b0;
            bit_cnt_next   = 3'd0;
            if (state_reg == DEV) begin
              if (shift_reg == DEVICE) begin
                state_next = ACK_DEV;
                busy_next  = 1'b1;
              end else begin
                state_next = IDLE;  // NACK: sda stays released
              end
            end else if (state_reg == ADDR) begin
              pointer_next = shift_reg;
              state_next   = ACK_ADDR;
            end else begin
              data_next    = shift_reg;
              addr_next    = pointer_reg;
              pointer_next = pointer_reg + 8'd1;
              valid_next   = 1'b1;
              state_next   = ACK_DATA;
            end
          end
        end

        ACK_DEV: begin
          if (scl_fall) state_next = ADDR;
        end

        ACK_ADDR, ACK_DATA: begin
          if (scl_fall) state_next = DATA;
        end

        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  // sda is pulled low purely as a function of being in an ACK state, so
  // it can never be driven outside one and is released on the same edge
  // that leaves it (including reset).
  logic ack_drive;
  assign ack_drive = (state_reg == ACK_DEV) || (state_reg == ACK_ADDR) ||
                     (state_reg == ACK_DATA);

  assign sda   = ack_drive ? 1'b0 : 1'bz;
  assign scl   = 1'bz;

  assign valid = valid_reg;
  assign addr  = addr_reg;
  assign data  = data_reg;
  assign busy  = busy_reg;

endmodule

// File: tb/tb_i2c_target_write.sv
// ---------------------------------------------------------------------------
// tb_i2c_target_write
//
// Directed plus randomized bench for i2c_target_write. A bus-level master
// drives scl/sda through pull-ups; a transaction-level model turns each
// list of bytes into the expected ACKs and the expected (addr, data)
// pulses, which are compared with what the design reports.
// ---------------------------------------------------------------------------
module tb_i2c_target_write;

  localparam logic [7:0] DEVICE = 8'hA0;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       m_scl = 1'b1;      // master scl level (1 = released)
  logic       m_sda_low = 1'b0;  // master pulls sda low
  logic       in_cond = 1'b0;    // master is generating START/STOP
  wire        scl;
  wire        sda;
  logic       valid;
  logic [7:0] addr;
  logic [7:0] data;
  logic       busy;

  pullup (scl);
  pullup (sda);
  assign scl = m_scl ? 1'bz : 1'b0;
  assign sda = m_sda_low ? 1'b0 : 1'bz;

  i2c_target_write #(.DEVICE(DEVICE)) dut (
    .clk   (clk),
    .rst   (rst),
    .scl   (scl),
    .sda   (sda),
    .valid (valid),
    .addr  (addr),
    .data  (data),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int q = 10;  // quarter scl period in clk

  // ---------------- monitors ----------------
  logic [15:0] obs_q[$];
  logic [15:0] exp_q[$];
  int   viol = 0;       // sda changed while scl high outside START/STOP
  int   wide = 0;       // valid high for more than one clk
  int   dut_low = 0;    // clocks the target holds sda low
  logic sda_prev = 1'b1;
  logic valid_prev = 1'b0;

  always @(negedge clk) begin
    if (valid === 1'b1) obs_q.push_back({addr, data});
    if (valid === 1'b1 && valid_prev === 1'b1) wide <= wide + 1;
    valid_prev <= valid;
    if (sda !== sda_prev && scl === 1'b1 && !in_cond) viol <= viol + 1;
    sda_prev <= sda;
    if (sda === 1'b0 && !m_sda_low) dut_low <= dut_low + 1;
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // START (or repeated START when scl is currently low); leaves scl low.
  task automatic do_start();
    if (m_scl == 1'b0) begin
      wait_clk(q);
      m_sda_low = 1'b0;
      wait_clk(q);
      m_scl = 1'b1;
      wait_clk(q);
    end
    in_cond = 1'b1;
    m_sda_low = 1'b1;
    wait_clk(q);
    in_cond = 1'b0;
    m_scl = 1'b0;
  endtask

  task automatic do_stop();
    wait_clk(q);
    m_sda_low = 1'b1;
    wait_clk(q);
    m_scl = 1'b1;
    wait_clk(q);
    in_cond = 1'b1;
    m_sda_low = 1'b0;
    wait_clk(q);
    in_cond = 1'b0;
    wait_clk(q);
  endtask

  // Sends the top n bits of b, MSB first; leaves scl low.
  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      wait_clk(q);
      m_sda_low = ~b[7 - i];
      wait_clk(q);
      m_scl = 1'b1;
      wait_clk(2 * q);
      m_scl = 1'b0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, output bit ack);
    send_bits(b, 8);
    wait_clk(q);
    m_sda_low = 1'b0;
    wait_clk(q);
    m_scl = 1'b1;
    wait_clk(q);
    ack = (sda === 1'b0);
    wait_clk(q);
    m_scl = 1'b0;
  endtask

  task automatic compare_sb(input string name);
    int n;
    check({name, "_npulse"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s_pulse%0d", name, i), obs_q[i], exp_q[i]);
    obs_q.delete();
    exp_q.delete();
  endtask

  // ---------------- transaction model + driver ----------------
  logic [7:0] tx_bytes[8];
  int         tx_len;

  task automatic run_txn(input string name);
    bit         ack;
    bit         match;
    logic [7:0] ptr;
    int         low0;
    match = (tx_bytes[0] == DEVICE);
    obs_q.delete();
    exp_q.delete();
    if (match && tx_len >= 2) begin
      ptr = tx_bytes[1];
      for (int k = 2; k < tx_len; k++) begin
        exp_q.push_back({ptr, tx_bytes[k]});
        ptr = ptr + 8'd1;
      end
    end
    low0 = dut_low;
    do_start();
    for (int i = 0; i < tx_len; i++) begin
      send_byte(tx_bytes[i], ack);
      check($sformatf("%s_ack%0d", name, i), ack, match);
      if (i == 0) check({name, "_busy"}, busy, match);
    end
    do_stop();
    wait_clk(4);
    check({name, "_busy_stop"}, busy, 1'b0);
    if (!match) check({name, "_nodrive"}, dut_low - low0, 0);
    $display("txn %s dev=%02h len=%0d expected_pulses=%0d observed_pulses=%0d",
             name, tx_bytes[0], tx_len, exp_q.size(), obs_q.size());
    compare_sb(name);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit ack;
    int low0;

    // Reset state
    wait_clk(3);
    check("rst_valid", valid, 1'b0);
    check("rst_addr", addr, 8'h00);
    check("rst_data", data, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_sda", sda, 1'b1);
    rst = 1'b0;
    wait_clk(1);
    check("rst_after_valid", valid, 1'b0);
    check("rst_after_busy", busy, 1'b0);
    wait_clk(5);

    // Basic write at scl period 1000 clk
    q = 250;
    tx_bytes[0] = 8'hA0; tx_bytes[1] = 8'h10; tx_bytes[2] = 8'h5A; tx_len = 3;
    run_txn("basic");
    q = 10;

    // Pointer wrap
    tx_bytes[0] = 8'hA0; tx_bytes[1] = 8'hFE; tx_bytes[2] = 8'h01;
    tx_bytes[3] = 8'h02; tx_bytes[4] = 8'h03; tx_len = 5;
    run_txn("wrap");

    // Wrong address and read bit: ignored entirely
    tx_bytes[0] = 8'hA2; tx_bytes[1] = 8'h11; tx_bytes[2] = 8'h22;
    tx_bytes[3] = 8'h00; tx_len = 4;
    run_txn("nack_a2");
    tx_bytes[0] = 8'hA1; tx_bytes[1] = 8'h00; tx_bytes[2] = 8'h33; tx_len = 3;
    run_txn("nack_a1");

    // Partial byte cut by repeated START
    obs_q.delete();
    exp_q.delete();
    exp_q.push_back({8'h30, 8'h77});
    do_start();
    send_byte(8'hA0, ack); check("rs_ack_dev1", ack, 1'b1);
    send_byte(8'h20, ack); check("rs_ack_addr1", ack, 1'b1);
    send_bits(8'hC5, 4);
    do_start();
    check("rs_busy_drop", busy, 1'b0);
    send_byte(8'hA0, ack); check("rs_ack_dev2", ack, 1'b1);
    send_byte(8'h30, ack); check("rs_ack_addr2", ack, 1'b1);
    send_byte(8'h77, ack); check("rs_ack_data", ack, 1'b1);
    do_stop();
    wait_clk(4);
    $display("txn rep_start expected_pulses=%0d observed_pulses=%0d",
             exp_q.size(), obs_q.size());
    compare_sb("rep_start");

    // Randomized transactions
    for (int t = 0; t < 8; t++) begin
      logic [7:0] r;
      r = 8'($urandom_range(0, 255));
      if (r == DEVICE) r = 8'hA1;
      tx_bytes[0] = ($urandom_range(0, 3) == 0) ? r : DEVICE;
      tx_len = 2 + $urandom_range(0, 4);
      for (int k = 1; k < tx_len; k++) tx_bytes[k] = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 1) tx_bytes[1] = 8'hFD;  // steer into wrap
      run_txn($sformatf("rand%0d", t));
    end

    // Reset during the ACK of the address byte
    obs_q.delete();
    exp_q.delete();
    do_start();
    send_byte(8'hA0, ack); check("rr_ack_dev", ack, 1'b1);
    send_bits(8'h44, 8);
    wait_clk(q);
    m_sda_low = 1'b0;
    wait_clk(2);
    check("rr_sda_ack", sda, 1'b0);
    rst = 1'b1;
    wait_clk(1);
    check("rr_sda_rel", sda, 1'b1);
    check("rr_valid", valid, 1'b0);
    check("rr_addr", addr, 8'h00);
    check("rr_data", data, 8'h00);
    check("rr_busy", busy, 1'b0);
    rst = 1'b0;
    wait_clk(1);
    check("rr_busy_after", busy, 1'b0);
    wait_clk(q - 4);
    m_scl = 1'b1;
    wait_clk(2 * q);
    m_scl = 1'b0;
    low0 = dut_low;
    send_byte(8'hA0, ack); check("rr_ignored0", ack, 1'b0);
    send_byte(8'h12, ack); check("rr_ignored1", ack, 1'b0);
    send_byte(8'h34, ack); check("rr_ignored2", ack, 1'b0);
    do_stop();
    wait_clk(4);
    check("rr_nodrive", dut_low - low0, 0);
    check("rr_busy_end", busy, 1'b0);
    $display("txn reset_mid expected_pulses=0 observed_pulses=%0d", obs_q.size());
    compare_sb("reset_mid");

    // Fresh transaction after reset works again
    tx_bytes[0] = 8'hA0; tx_bytes[1] = 8'h42; tx_bytes[2] = 8'h99; tx_len = 3;
    run_txn("post_reset");

    // Bus-wide properties
    check("bus_sda_stable", viol, 0);
    check("valid_width", wide, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
